// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// Data normally wins; a saturating starvation counter forces an instruction grant.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [7:0]  i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [7:0]  m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam int CW = ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [7:0]    addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          side_i_q, side_i_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          grant_i, grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      side_i_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      side_i_q  <= side_i_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Instruction only wins when data is absent or the fetch has been starved long enough.
  always_comb begin
    grant_i = i_req && (!d_req || (starve_q == LIMIT));
    grant_d = d_req && !grant_i;
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    side_i_d  = side_i_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d  = BUSY_I;
          addr_d   = i_addr;
          we_d     = 1'b0;
          side_i_d = 1'b1;
          starve_d = '0;
        end else if (grant_d) begin
          state_d  = BUSY_D;
          addr_d   = d_addr;
          we_d     = d_we;
          wdata_d  = d_wdata;
          side_i_d = 1'b0;
          if (i_req && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          i_rdata_d = m_rdata;
          state_d   = RESP;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          if (!we_q) begin
            d_rdata_d = m_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The memory port is driven purely from the latched copy so requester changes cannot leak in.
  always_comb begin
    m_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
    m_we    = (state_q == BUSY_D) && we_q;
    m_addr  = addr_q;
    m_wdata = wdata_q;
    i_ready = (state_q == RESP) && side_i_q;
    d_ready = (state_q == RESP) && !side_i_q;
    i_rdata = i_rdata_q;
    d_rdata = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses, a negedge
// monitor pops and compares them whenever a ready pulse appears.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  typedef struct {
    bit          isInstr;
    logic [31:0] data;
    int          expCyc;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          mReqTotal = 0;
  int          waitCycles = 0;
  int          waitCnt = 0;
  bit          ackTie = 1'b0;
  bit          checkMem = 1'b0;
  logic [7:0]  expAddr = '0;
  logic        expWe = 1'b0;
  logic [31:0] expWdata = '0;
  logic [31:0] mem [256];

  mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_ready(i_ready),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ready(d_ready),
    .d_rdata(d_rdata),
    .m_req(m_req),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_ack(m_ack),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: programmable wait states, optional ack tied high, stores written on ack.
  assign m_ack   = ackTie | (m_req && (waitCnt >= waitCycles));
  assign m_rdata = mem[m_addr];

  always @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < 256; a++) mem[a] <= 32'(a);
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'h0000_0000;
      mem[8'h30] <= 32'h3030_3030;
      mem[8'h31] <= 32'h3131_3131;
      mem[8'h40] <= 32'h4040_BBBB;
      mem[8'h41] <= 32'h4141_CCCC;
      mem[8'h50] <= 32'h5050_AAAA;
      waitCnt    <= 0;
    end else begin
      if (m_req && m_ack && m_we) mem[m_addr] <= m_wdata;
      if (m_req && !m_ack) waitCnt <= waitCnt + 1;
      else waitCnt <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops one expectation per ready pulse and watches the memory port.
  always @(negedge clk) begin
    exp_t e;
    if (m_req) mReqTotal++;
    if (!reset) begin
      checkOutput("m_we without m_req", {31'b0, m_we & ~m_req}, 32'h0);
      checkOutput("both readies", {31'b0, i_ready & d_ready}, 32'h0);
    end
    if (checkMem && m_req) begin
      checkOutput("m_addr", {24'b0, m_addr}, {24'b0, expAddr});
      checkOutput("m_we", {31'b0, m_we}, {31'b0, expWe});
      checkOutput("m_wdata", m_wdata, expWdata);
    end
    if (i_ready || d_ready) begin
      if (sb.size() == 0) begin
        failNow("unexpected ready pulse");
      end else begin
        e = sb.pop_front();
        checkOutput("ready side", {31'b0, i_ready}, {31'b0, e.isInstr});
        checkOutput(e.isInstr ? "i_rdata" : "d_rdata", e.isInstr ? i_rdata : d_rdata, e.data);
        if (e.expCyc >= 0) checkOutput("ready latency", 32'(cyc), 32'(e.expCyc));
      end
    end
  end

  task automatic pushExp(input bit isInstr, input logic [31:0] data, input int expCyc);
    exp_t e;
    e.isInstr = isInstr;
    e.data    = data;
    e.expCyc  = expCyc;
    sb.push_back(e);
  endtask

  // Called just after a rising edge with the arbiter idle.
  task automatic applyStimulus(input bit isInstr, input bit we, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input int waits);
    waitCycles = waits;
    pushExp(isInstr, expData, cyc + 2 + waits);
    if (isInstr) begin
      i_addr = addr;
      i_req  = 1'b1;
    end else begin
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
      d_req   = 1'b1;
    end
  endtask

  // Waits until every expectation is consumed, then drops both requests.
  task automatic waitDone(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      failNow({"timeout waiting for ", name});
      sb.delete();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  task automatic nextIssue();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int mStart;
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset i_ready", {31'b0, i_ready}, 32'h0);
    checkOutput("reset d_ready", {31'b0, d_ready}, 32'h0);
    checkOutput("reset m_req", {31'b0, m_req}, 32'h0);
    checkOutput("reset i_rdata", i_rdata, 32'h0);
    checkOutput("reset d_rdata", d_rdata, 32'h0);
    reset = 1'b0;

    $display("[TB] zero-wait load with ack tied high");
    ackTie = 1'b1;
    checkMem = 1'b1; expAddr = 8'h10; expWe = 1'b0; expWdata = 32'h0;
    nextIssue();
    mStart = mReqTotal;
    applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 0);
    waitDone(20, "zero-wait load");
    checkOutput("zero-wait m_req cycles", 32'(mReqTotal - mStart), 32'd1);
    ackTie = 1'b0;

    $display("[TB] store with two wait cycles");
    expAddr = 8'h20; expWe = 1'b1; expWdata = 32'h12345678;
    nextIssue();
    mStart = mReqTotal;
    applyStimulus(1'b0, 1'b1, 8'h20, 32'h12345678, 32'hDEADBEEF, 2);
    waitDone(20, "store");
    checkOutput("store m_req cycles", 32'(mReqTotal - mStart), 32'd3);

    $display("[TB] load back stored word");
    expAddr = 8'h20; expWe = 1'b0; expWdata = 32'h0;
    nextIssue();
    applyStimulus(1'b0, 1'b0, 8'h20, 32'h0, 32'h12345678, 0);
    waitDone(20, "load back");

    $display("[TB] requester inputs change in flight");
    expAddr = 8'h30; expWe = 1'b0; expWdata = 32'h0;
    nextIssue();
    applyStimulus(1'b0, 1'b0, 8'h30, 32'h0, 32'h3030_3030, 3);
    nextIssue();
    d_addr  = 8'h31;
    d_we    = 1'b1;
    d_wdata = 32'hFFFF_0000;
    waitDone(20, "in-flight change");
    checkMem = 1'b0;

    $display("[TB] fetch with early deassert, then held request re-issues");
    nextIssue();
    applyStimulus(1'b1, 1'b0, 8'h40, 32'h0, 32'h4040_BBBB, 1);
    nextIssue();
    i_req  = 1'b0;
    i_addr = 8'h41;
    waitDone(20, "deassert mid-flight");
    nextIssue();
    applyStimulus(1'b1, 1'b0, 8'h41, 32'h0, 32'h4141_CCCC, 0);
    pushExp(1'b1, 32'h4141_CCCC, cyc + 5);
    waitDone(30, "held re-request");

    $display("[TB] starvation: both requests held");
    nextIssue();
    waitCycles = 1;
    for (int k = 0; k < 8; k++) pushExp((k % 4) == 3, ((k % 4) == 3) ? 32'h4040_BBBB : 32'h5050_AAAA, -1);
    i_addr = 8'h40; d_addr = 8'h50; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    waitDone(200, "grant order");

    $display("[TB] reset during instruction fetch");
    nextIssue();
    waitCycles = 100;
    i_addr = 8'h41;
    i_req  = 1'b1;
    nextIssue();
    checkOutput("busy m_req before reset", {31'b0, m_req}, 32'h1);
    reset = 1'b1;
    nextIssue();
    checkOutput("abort m_req", {31'b0, m_req}, 32'h0);
    checkOutput("abort i_ready", {31'b0, i_ready}, 32'h0);
    checkOutput("abort i_rdata", i_rdata, 32'h0);
    checkOutput("abort d_rdata", d_rdata, 32'h0);
    reset = 1'b0;
    i_req = 1'b0;
    waitCycles = 0;
    repeat (6) @(posedge clk);

    $display("[TB] reset clears starvation count");
    nextIssue();
    pushExp(1'b0, 32'h5050_AAAA, -1);
    pushExp(1'b0, 32'h5050_AAAA, -1);
    i_addr = 8'h40; d_addr = 8'h50; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    waitDone(100, "pre-reset grants");
    reset = 1'b1;
    nextIssue();
    reset = 1'b0;
    nextIssue();
    for (int k = 0; k < 4; k++) pushExp(k == 3, (k == 3) ? 32'h4040_BBBB : 32'h5050_AAAA, -1);
    i_req = 1'b1; d_req = 1'b1;
    waitDone(100, "post-reset grant order");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
